// File: rtl/led_pattern_fader.sv
// Per-LED PWM fader driven by the CPU output pattern; levels ramp one step per fade tick.
// Define LED_FADER_INSTANT_EN to bypass the ramp and jump levels straight to their endpoint.
module led_pattern_fader #(
    parameter int unsigned FREQ     = 0,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] patternIn,
    input  logic       patternValid,
    output logic [7:0] ledOut,
    output logic       busy
);

    localparam int unsigned TW = (FREQ > 0) ? $clog2(FREQ + 1) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(FREQ);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [7:0]          target;
    logic [TW-1:0]       tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level     [8];
    logic [PWM_BITS-1:0] level_nxt [8];
    logic [7:0]          led_nxt;
    logic [7:0]          off_end;
    logic                tick;

    assign tick = (tick_cnt == TICK_MAX);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef LED_FADER_INSTANT_EN
            level_nxt[i] = target[i] ? MAX : '0;
`else
            level_nxt[i] = level[i];
            if (tick) begin
                if (target[i] && (level[i] != MAX)) begin
                    level_nxt[i] = level[i] + ONE;
                end else if (!target[i] && (level[i] != '0)) begin
                    level_nxt[i] = level[i] - ONE;
                end
            end
`endif
        end
    end

    // Outputs depend only on registers, so pattern glitches never reach the pins.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            led_nxt[i] = (level[i] == MAX) | (level[i] > pwm_cnt);
            off_end[i] = (level[i] != (target[i] ? MAX : '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= '0;
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            ledOut   <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                level[i] <= '0;
            end
        end else begin
            if (patternValid) begin
                target <= patternIn;
            end
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            pwm_cnt  <= pwm_cnt + ONE;
            ledOut   <= led_nxt;
            busy     <= |off_end;
            for (int i = 0; i < 8; i++) begin
                level[i] <= level_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_fader.sv
// Scoreboard bench for led_pattern_fader: expected outputs are queued per edge
// when stimulus is driven and compared on the falling clock edge.
module tb_led_pattern_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_s;
    logic [7:0] pin, pin_s;
    logic       pv, pv_s;
    logic [7:0] led, led_s;
    logic       busy, busy_s;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rst_edge = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    led_pattern_fader #(.FREQ(0), .PWM_BITS(4)) dut (
        .clk(clk), .rst(rst), .patternIn(pin), .patternValid(pv),
        .ledOut(led), .busy(busy)
    );

    led_pattern_fader #(.FREQ(1000), .PWM_BITS(4)) dut_slow (
        .clk(clk), .rst(rst_s), .patternIn(pin_s), .patternValid(pv_s),
        .ledOut(led_s), .busy(busy_s)
    );

    typedef struct {
        string      nm;
        int         e;
        logic [7:0] led;
        logic       busy;
    } exp_t;

    typedef struct {
        string nm;
        int    e0;
        int    hi1;
    } duty_t;

    exp_t  sb[$];
    duty_t dq[$];

    function automatic int pwm_at(int e, int r);
        return (e - r) & 15;
    endfunction

    function automatic logic exp_bit(int lv, int p);
        return (lv == 15) || (lv > p);
    endfunction

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Level after edge x for the AA -> 55 -> AA reversal scenario.
    function automatic int lv_rev(int b, int x, int k2, int k3);
        if (b % 2 == 1) begin
            if (x <= k2) return 15;
            if (x <= k3) return 15 - (x - k2);
            return min_i(10 + (x - k3), 15);
        end
        if (x <= k2) return 0;
        if (x <= k3) return x - k2;
        return (5 - (x - k3) > 0) ? 5 - (x - k3) : 0;
    endfunction

    function automatic logic [7:0] tgt_rev(int x, int k2, int k3);
        if (x < k2) return 8'hAA;
        if (x < k3) return 8'h55;
        return 8'hAA;
    endfunction

    task automatic test_reset;
        int first;
        @(negedge clk);
        rst = 1'b1; rst_s = 1'b1;
        pin = 8'hFF; pv = 1'b1;
        pin_s = 8'hFF; pv_s = 1'b1;
        first = edge_n + 1;
        for (int i = 0; i < 4; i++) sb.push_back('{"reset", first + i, 8'h00, 1'b0});
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (edge_n == first + 2) begin
                rst = 1'b0; rst_s = 1'b0; pv = 1'b0; pv_s = 1'b0;
                rst_edge = edge_n;
            end
            while (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x = sb.pop_front();
                checks++;
                if (led !== x.led || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s edge %0d: ledOut=%h busy=%b, expected ledOut=%h busy=%b",
                             x.nm, x.e, led, busy, x.led, x.busy);
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL reset timeout: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

`ifdef LED_FADER_INSTANT_EN
    task automatic test_instant;
        int k, m;
        @(negedge clk);
        pin = 8'hCC; pv = 1'b1;
        k = edge_n + 1;
        m = k + 5;
        sb.push_back('{"inst_k", k, 8'h00, 1'b0});
        sb.push_back('{"inst_k1", k + 1, 8'h00, 1'b1});
        for (int e = k + 2; e <= m; e++) sb.push_back('{"inst_cc", e, 8'hCC, 1'b0});
        sb.push_back('{"inst_m1", m + 1, 8'hCC, 1'b1});
        for (int e = m + 2; e <= m + 6; e++) sb.push_back('{"inst_33", e, 8'h33, 1'b0});
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (edge_n == k) pv = 1'b0;
            if (edge_n == m - 1) begin pin = 8'h33; pv = 1'b1; end
            if (edge_n == m) pv = 1'b0;
            while (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x = sb.pop_front();
                checks++;
                if (led !== x.led || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s edge %0d: ledOut=%h busy=%b, expected ledOut=%h busy=%b",
                             x.nm, x.e, led, busy, x.led, x.busy);
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL instant timeout: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask
`else
    task automatic test_fade_in;
        int k, lv, p;
        logic [7:0] el;
        @(negedge clk);
        pin = 8'hAA; pv = 1'b1;
        k = edge_n + 1;
        for (int j = 0; j <= 20; j++) begin
            lv = (j == 0) ? 0 : min_i(j - 1, 15);
            p = pwm_at(k + j - 1, rst_edge);
            el = '0;
            for (int b = 1; b < 8; b += 2) el[b] = exp_bit(lv, p);
            sb.push_back('{"fade_in", k + j, el, (j >= 1 && j <= 15)});
        end
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            pv = 1'b0;
            while (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x = sb.pop_front();
                checks++;
                if (led !== x.led || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s edge %0d: ledOut=%h busy=%b, expected ledOut=%h busy=%b",
                             x.nm, x.e, led, busy, x.led, x.busy);
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL fade_in timeout: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reversal;
        int k2, k3, p, lv;
        logic [7:0] el, tg;
        logic eb;
        @(negedge clk);
        pin = 8'h55; pv = 1'b1;
        k2 = edge_n + 1;
        k3 = k2 + 5;
        for (int e = k2; e <= k3 + 20; e++) begin
            p = pwm_at(e - 1, rst_edge);
            tg = tgt_rev(e - 1, k2, k3);
            el = '0;
            eb = 1'b0;
            for (int b = 0; b < 8; b++) begin
                lv = lv_rev(b, e - 1, k2, k3);
                el[b] = exp_bit(lv, p);
                if (lv != (tg[b] ? 15 : 0)) eb = 1'b1;
            end
            sb.push_back('{"reversal", e, el, eb});
        end
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (edge_n == k2) pv = 1'b0;
            if (edge_n == k3 - 1) begin pin = 8'hAA; pv = 1'b1; end
            if (edge_n == k3) pv = 1'b0;
            while (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x = sb.pop_front();
                checks++;
                if (led !== x.led || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s edge %0d: ledOut=%h busy=%b, expected ledOut=%h busy=%b",
                             x.nm, x.e, led, busy, x.led, x.busy);
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL reversal timeout: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_midfade;
        int k, lv, p;
        logic [7:0] el;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_edge = edge_n;
        pin = 8'hAA; pv = 1'b1;
        k = edge_n + 1;
        for (int j = 0; j <= 25; j++) begin
            el = '0;
            if (j < 7) begin
                lv = (j == 0) ? 0 : j - 1;
                p = pwm_at(k + j - 1, rst_edge);
                for (int b = 1; b < 8; b += 2) el[b] = exp_bit(lv, p);
            end
            sb.push_back('{"reset_mid", k + j, el, (j >= 1 && j < 7)});
        end
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (edge_n == k) pv = 1'b0;
            if (edge_n == k + 6) rst = 1'b1;
            if (edge_n == k + 7) begin rst = 1'b0; rst_edge = edge_n; end
            while (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x = sb.pop_front();
                checks++;
                if (led !== x.led || busy !== x.busy) begin
                    errors++;
                    $display("FAIL %s edge %0d: ledOut=%h busy=%b, expected ledOut=%h busy=%b",
                             x.nm, x.e, led, busy, x.led, x.busy);
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL reset_mid timeout: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_duty;
        int rs, n1, n0, nb;
        @(negedge clk);
        rst_s = 1'b1; pv_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b0;
        rs = edge_n;
        pin_s = 8'h02; pv_s = 1'b1;
        // Ticks land on edges rs+1001*m; the 4th and 8th tick set levels 4 and 8.
        dq.push_back('{"duty4", rs + 4005, 4});
        dq.push_back('{"duty8", rs + 8009, 8});
        n1 = 0; n0 = 0; nb = 0;
        for (int c = 0; c < 9100 && dq.size() > 0; c++) begin
            @(negedge clk);
            pv_s = 1'b0;
            if (edge_n >= dq[0].e0 && edge_n < dq[0].e0 + 16) begin
                n1 += int'(led_s[1]);
                n0 += int'(led_s[0]);
                nb += int'(busy_s);
            end
            if (edge_n == dq[0].e0 + 15) begin
                duty_t d = dq.pop_front();
                checks++;
                if (n1 != d.hi1 || n0 != 0 || nb != 16) begin
                    errors++;
                    $display("FAIL %s: bit1 highs=%0d bit0 highs=%0d busy=%0d, expected %0d 0 16",
                             d.nm, n1, n0, nb, d.hi1);
                end
                n1 = 0; n0 = 0; nb = 0;
            end
        end
        checks++;
        if (dq.size() > 0) begin
            errors++;
            $display("FAIL duty timeout: %0d pending, expected 0", dq.size());
            dq.delete();
        end
    endtask
`endif

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        pin = '0; pin_s = '0;
        pv = 1'b0; pv_s = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
`ifdef LED_FADER_INSTANT_EN
        test_instant();
`else
        test_fade_in();
        test_reversal();
        test_reset_midfade();
        test_duty();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
